// File: rtl/alu74181_nibble_seq_if.sv
// alu74181_nibble_seq_if: request/response handshake bundle for the nibble sequencer
interface alu74181_nibble_seq_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic [3:0]   req_s;
   logic         req_m;
   logic         req_cn;
   logic         abort;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_f;
   logic         rsp_cn4;
   logic         rsp_aeqb;
   modport master (
      output req_valid, req_a, req_b, req_s, req_m, req_cn, abort, rsp_ready,
      input  req_ready, rsp_valid, rsp_f, rsp_cn4, rsp_aeqb
   );
   modport slave (
      input  req_valid, req_a, req_b, req_s, req_m, req_cn, abort, rsp_ready,
      output req_ready, rsp_valid, rsp_f, rsp_cn4, rsp_aeqb
   );
endinterface

// File: rtl/alu74181_nibble_seq.sv
// alu74181_nibble_seq: drives one 74181 slice nibble by nibble to form a wide ALU
module alu74181_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                        clock,
   input  logic                        resetb,
   alu74181_nibble_seq_if.slave        bus,
   output logic [3:0]                  alu_a,
   output logic [3:0]                  alu_b,
   output logic [3:0]                  alu_s,
   output logic                        alu_m,
   output logic                        alu_cn,
   input  logic [3:0]                  alu_f,
   input  logic                        alu_cn4,
   input  logic                        alu_aeqb
);
   localparam int W = 4 * NIBBLES;
   localparam logic [2:0] LAST = 3'(NIBBLES - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t       state_q, state_d;
   logic [W-1:0] a_q, b_q, f_q;
   logic [3:0]   s_q;
   logic         m_q, cn_q, carry_q, aeqb_q;
   logic [2:0]   idx_q;
   logic         run, accept;
   assign run = state_q == RUN;
   assign accept = state_q == IDLE && bus.req_valid;
   assign bus.rsp_f = f_q;
   assign bus.rsp_cn4 = carry_q;
   assign bus.rsp_aeqb = aeqb_q;
   // state register
   always_ff @(posedge clock or negedge resetb)
      if (!resetb) state_q <= IDLE;
      else state_q <= state_d;
   // next state and handshake flags; abort only matters while running
   always_comb begin
      state_d = state_q == IDLE ? (bus.req_valid ? RUN : IDLE)
              : run ? (bus.abort ? IDLE : idx_q == LAST ? DONE : RUN)
              : state_q == DONE ? (bus.rsp_ready ? IDLE : DONE) : IDLE;
      bus.req_ready = state_q == IDLE;
      bus.rsp_valid = state_q == DONE;
   end
   // ALU drive: current nibble and chained carry in RUN, neutral values otherwise
   always_comb begin
      alu_a = run ? 4'(a_q >> {idx_q, 2'b00}) : 4'd0;
      alu_b = run ? 4'(b_q >> {idx_q, 2'b00}) : 4'd0;
      alu_s = run ? s_q : 4'd0;
      alu_m = run ? m_q : 1'b1;
      alu_cn = run ? (idx_q == 3'd0 ? cn_q : carry_q) : 1'b1;
   end
   // operand capture on accept, then per-nibble result, carry and A=B accumulation
   always_ff @(posedge clock or negedge resetb)
      if (!resetb) begin
         a_q <= '0;
         b_q <= '0;
         s_q <= '0;
         m_q <= 1'b1;
         cn_q <= 1'b1;
         idx_q <= '0;
         f_q <= '0;
         carry_q <= 1'b1;
         aeqb_q <= 1'b0;
      end else if (accept) begin
         a_q <= bus.req_a;
         b_q <= bus.req_b;
         s_q <= bus.req_s;
         m_q <= bus.req_m;
         cn_q <= bus.req_cn;
         idx_q <= '0;
         f_q <= '0;
         aeqb_q <= 1'b1;
      end else if (run && !bus.abort) begin
         f_q <= f_q | (W'(alu_f) << {idx_q, 2'b00});
         carry_q <= alu_cn4;
         aeqb_q <= aeqb_q & alu_aeqb;
         idx_q <= idx_q + 3'd1;
      end
endmodule

// File: tb/tb_alu74181_nibble_seq.sv
// tb_alu74181_nibble_seq: randomized and directed checks of the 16-bit nibble sequencer
module tb_alu74181_nibble_seq;
   logic        clock;
   logic        resetb;
   logic [3:0]  alu_a, alu_b, alu_s, alu_f;
   logic        alu_m, alu_cn, alu_cn4, alu_aeqb;
   logic [17:0] alu_r;
   int          total, bad;
   logic [15:0] got_f;
   logic        got_cn4, got_aeqb;
   int          got_lat;

   alu74181_nibble_seq_if #(.NIBBLES(4)) bus();

   alu74181_nibble_seq #(.NIBBLES(4)) dut (
      .clock(clock), .resetb(resetb), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
      .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_aeqb(alu_aeqb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // 74181 datasheet behaviour (active-high data) at width w: returns {aeqb, cn4, f}
   function automatic logic [17:0] ref181(input logic [15:0] a, b, input logic [3:0] s,
                                          input logic m, cn, input int w);
      logic [16:0] mk, x, y, ny, sum, lg;
      logic [15:0] f;
      mk = (17'd1 << w) - 17'd1;
      x = {1'b0, a} & mk;
      y = {1'b0, b} & mk;
      ny = ~y & mk;
      case (s)
         4'h0: sum = x;
         4'h1: sum = x | y;
         4'h2: sum = x | ny;
         4'h3: sum = mk;
         4'h4: sum = x + (x & ny);
         4'h5: sum = (x | y) + (x & ny);
         4'h6: sum = x + ny;
         4'h7: sum = (x & ny) + mk;
         4'h8: sum = x + (x & y);
         4'h9: sum = x + y;
         4'hA: sum = (x | ny) + (x & y);
         4'hB: sum = (x & y) + mk;
         4'hC: sum = x + x;
         4'hD: sum = (x | y) + x;
         4'hE: sum = (x | ny) + x;
         default: sum = x + mk;
      endcase
      sum = sum + {16'd0, ~cn};
      case (s)
         4'h0: lg = ~x;
         4'h1: lg = ~(x | y);
         4'h2: lg = ~x & y;
         4'h3: lg = '0;
         4'h4: lg = ~(x & y);
         4'h5: lg = ny;
         4'h6: lg = x ^ y;
         4'h7: lg = x & ny;
         4'h8: lg = ~x | y;
         4'h9: lg = ~(x ^ y);
         4'hA: lg = y;
         4'hB: lg = x & y;
         4'hC: lg = mk;
         4'hD: lg = x | ny;
         4'hE: lg = x | y;
         default: lg = x;
      endcase
      f = (m ? lg[15:0] : sum[15:0]) & mk[15:0];
      return {f == mk[15:0], ~sum[w], f};
   endfunction

   // the external 74181 slice, combinational from the sequencer outputs
   always_comb begin
      alu_r = ref181({12'd0, alu_a}, {12'd0, alu_b}, alu_s, alu_m, alu_cn, 4);
      alu_f = alu_r[3:0];
      alu_cn4 = alu_r[16];
      alu_aeqb = alu_r[17];
   end

   // one full operation: wait for ready, accept, measure latency, take response
   task automatic do_op(input logic [15:0] a, b, input logic [3:0] s, input logic m, cn);
      int guard;
      guard = 0;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_a = a;
      bus.req_b = b;
      bus.req_s = s;
      bus.req_m = m;
      bus.req_cn = cn;
      while (!bus.req_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = 1'b0;
      got_lat = 0;
      while (!bus.rsp_valid && got_lat < 50) begin
         @(negedge clock);
         got_lat++;
      end
      got_f = bus.rsp_f;
      got_cn4 = bus.rsp_cn4;
      got_aeqb = bus.rsp_aeqb;
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetb = 1'b0;
      repeat (3) @(negedge clock);
      resetb = 1'b1;
      @(negedge clock);
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      total++; if (bus.rsp_f !== 16'h0000) begin bad++; $display("FAIL reset_rsp_f got=%h exp=0000", bus.rsp_f); end
      total++; if (bus.rsp_cn4 !== 1'b1) begin bad++; $display("FAIL reset_rsp_cn4 got=%b exp=1", bus.rsp_cn4); end
      total++; if (bus.rsp_aeqb !== 1'b0) begin bad++; $display("FAIL reset_rsp_aeqb got=%b exp=0", bus.rsp_aeqb); end
      total++; if ({alu_a, alu_b, alu_s, alu_m, alu_cn} !== 14'b00000000000011) begin
         bad++; $display("FAIL reset_alu_drive got=%h/%h/%h/%b/%b exp=0/0/0/1/1", alu_a, alu_b, alu_s, alu_m, alu_cn);
      end
   endtask

   task automatic test_add();
      do_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
      total++; if (got_f !== 16'h0100) begin bad++; $display("FAIL add_f got=%h exp=0100", got_f); end
      total++; if (got_cn4 !== 1'b1) begin bad++; $display("FAIL add_cn4 got=%b exp=1", got_cn4); end
      total++; if (got_lat !== 4) begin bad++; $display("FAIL add_latency got=%0d exp=4", got_lat); end
      total++; if ({alu_m, alu_cn, alu_s} !== 6'b110000) begin
         bad++; $display("FAIL idle_alu_drive got=%b/%b/%h exp=1/1/0", alu_m, alu_cn, alu_s);
      end
   endtask

   task automatic test_carry();
      do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
      total++; if (got_f !== 16'h0000) begin bad++; $display("FAIL carry_f got=%h exp=0000", got_f); end
      total++; if (got_cn4 !== 1'b0) begin bad++; $display("FAIL carry_cn4 got=%b exp=0", got_cn4); end
   endtask

   task automatic test_compare();
      do_op(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1);
      total++; if (got_f !== 16'hFFFF) begin bad++; $display("FAIL cmp_eq_f got=%h exp=ffff", got_f); end
      total++; if (got_aeqb !== 1'b1) begin bad++; $display("FAIL cmp_eq_aeqb got=%b exp=1", got_aeqb); end
      total++; if (got_cn4 !== 1'b1) begin bad++; $display("FAIL cmp_eq_cn4 got=%b exp=1", got_cn4); end
      do_op(16'h1235, 16'h1234, 4'b0110, 1'b0, 1'b1);
      total++; if (got_f !== 16'h0000) begin bad++; $display("FAIL cmp_ne_f got=%h exp=0000", got_f); end
      total++; if (got_aeqb !== 1'b0) begin bad++; $display("FAIL cmp_ne_aeqb got=%b exp=0", got_aeqb); end
      total++; if (got_cn4 !== 1'b0) begin bad++; $display("FAIL cmp_ne_cn4 got=%b exp=0", got_cn4); end
   endtask

   task automatic test_logic_xor();
      do_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);
      total++; if (got_f !== 16'h0FF0) begin bad++; $display("FAIL xor_f got=%h exp=0ff0", got_f); end
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic [3:0]  s;
      logic        m, cn;
      logic [17:0] e;
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         b = (i % 8 == 0) ? a : 16'($urandom);
         s = 4'($urandom);
         m = 1'($urandom);
         cn = 1'($urandom);
         e = ref181(a, b, s, m, cn, 16);
         do_op(a, b, s, m, cn);
         total++; if (got_f !== e[15:0]) begin bad++; $display("FAIL rand_f a=%h b=%h s=%h m=%b cn=%b got=%h exp=%h", a, b, s, m, cn, got_f, e[15:0]); end
         total++; if (got_cn4 !== e[16]) begin bad++; $display("FAIL rand_cn4 a=%h b=%h s=%h m=%b cn=%b got=%b exp=%b", a, b, s, m, cn, got_cn4, e[16]); end
         total++; if (got_aeqb !== e[17]) begin bad++; $display("FAIL rand_aeqb a=%h b=%h s=%h m=%b got=%b exp=%b", a, b, s, m, got_aeqb, e[17]); end
         total++; if (got_lat !== 4) begin bad++; $display("FAIL rand_latency got=%0d exp=4", got_lat); end
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] e;
      logic [15:0] f0;
      int          lat;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_a = 16'h1234;
      bus.req_b = 16'h1111;
      bus.req_s = 4'b1001;
      bus.req_m = 1'b0;
      bus.req_cn = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.req_a = 16'hABCD;
      bus.req_b = 16'h1234;
      bus.req_s = 4'b0110;
      bus.req_cn = 1'b0;
      lat = 0;
      while (!bus.rsp_valid && lat < 50) begin @(negedge clock); lat++; end
      f0 = bus.rsp_f;
      total++; if (f0 !== 16'h2345) begin bad++; $display("FAIL bp_first_f got=%h exp=2345", f0); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         total++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_f !== 16'h2345) begin
            bad++; $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b f=%h exp 1/0/2345", i, bus.rsp_valid, bus.req_ready, bus.rsp_f);
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      bus.rsp_ready = 1'b0;
      total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release got ready=%b valid=%b exp 1/0", bus.req_ready, bus.rsp_valid);
      end
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = 1'b0;
      lat = 0;
      while (!bus.rsp_valid && lat < 50) begin @(negedge clock); lat++; end
      e = ref181(16'hABCD, 16'h1234, 4'b0110, 1'b0, 1'b0, 16);
      total++; if (bus.rsp_f !== e[15:0] || bus.rsp_cn4 !== e[16]) begin
         bad++; $display("FAIL bp_second got f=%h cn4=%b exp f=%h cn4=%b", bus.rsp_f, bus.rsp_cn4, e[15:0], e[16]);
      end
      total++; if (lat !== 4) begin bad++; $display("FAIL bp_second_latency got=%0d exp=4", lat); end
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      bus.rsp_ready = 1'b0;
   endtask

   // start an add and stop after two nibbles have been captured
   task automatic start_two_nibbles();
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_a = 16'hFFFF;
      bus.req_b = 16'h0001;
      bus.req_s = 4'b1001;
      bus.req_m = 1'b0;
      bus.req_cn = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_abort();
      int seen;
      start_two_nibbles();
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL abort_idle got ready=%b valid=%b exp 1/0", bus.req_ready, bus.rsp_valid);
      end
      seen = 0;
      repeat (6) begin @(negedge clock); if (bus.rsp_valid) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_rsp got=%0d valid cycles exp=0", seen); end
      do_op(16'h0001, 16'h0000, 4'b1001, 1'b0, 1'b1);
      total++; if (got_f !== 16'h0001 || got_cn4 !== 1'b1 || got_lat !== 4) begin
         bad++; $display("FAIL abort_next_add got f=%h cn4=%b lat=%0d exp 0001/1/4", got_f, got_cn4, got_lat);
      end
   endtask

   task automatic test_reset_mid_run();
      start_two_nibbles();
      resetb = 1'b0;
      #1;
      total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_f !== 16'h0000
                   || bus.rsp_cn4 !== 1'b1 || bus.rsp_aeqb !== 1'b0) begin
         bad++; $display("FAIL midrun_reset_rsp got ready=%b valid=%b f=%h cn4=%b aeqb=%b exp 1/0/0000/1/0",
                         bus.req_ready, bus.rsp_valid, bus.rsp_f, bus.rsp_cn4, bus.rsp_aeqb);
      end
      total++; if ({alu_a, alu_b, alu_s, alu_m, alu_cn} !== 14'b00000000000011) begin
         bad++; $display("FAIL midrun_reset_alu got=%h/%h/%h/%b/%b exp=0/0/0/1/1", alu_a, alu_b, alu_s, alu_m, alu_cn);
      end
      @(negedge clock);
      resetb = 1'b1;
      do_op(16'h0001, 16'h0000, 4'b1001, 1'b0, 1'b1);
      total++; if (got_f !== 16'h0001 || got_cn4 !== 1'b1 || got_lat !== 4) begin
         bad++; $display("FAIL reset_next_add got f=%h cn4=%b lat=%0d exp 0001/1/4", got_f, got_cn4, got_lat);
      end
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int wrong;
      wrong = 0;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.req_a = 16'h00FF;
      bus.req_b = 16'h0001;
      bus.req_s = 4'b1001;
      bus.req_m = 1'b0;
      bus.req_cn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (bus.req_ready) acc.push_back(c);
         if (bus.rsp_valid && bus.rsp_f !== 16'h0100) wrong++;
         @(negedge clock);
      end
      bus.req_valid = 1'b0;
      repeat (8) @(negedge clock);
      bus.rsp_ready = 1'b0;
      total++; if (acc.size() < 3 || acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
         bad++; $display("FAIL b2b_spacing got accepts=%0d first gap=%0d exp gap=6", acc.size(), acc.size() > 1 ? acc[1] - acc[0] : -1);
      end
      total++; if (wrong !== 0) begin bad++; $display("FAIL b2b_result got=%0d wrong responses exp=0", wrong); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      resetb = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_s = '0;
      bus.req_m = 1'b0;
      bus.req_cn = 1'b1;
      bus.abort = 1'b0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_add();
      test_carry();
      test_compare();
      test_logic_xor();
      test_random();
      test_backpressure();
      test_abort();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule

// File: doc/alu74181_nibble_seq.md
# alu74181_nibble_seq

Multi-nibble sequencer for the 4-bit 74181 ALU in the user project area. It accepts a wide operation (operands, S, M, Cn) over a valid/ready handshake. It then drives one external 74181 instance one nibble per cycle, LSB first, chaining the ALU carry between nibbles, and returns the assembled result, carry-out and A=B flag over a second valid/ready handshake. This makes the single 74181 slice usable as a NIBBLES×4-bit ALU without replicating it.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation; range 1..8; W = 4*NIBBLES.
- clock  in  1  single clock; all state on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_s  in  4  74181 function select S3..S0.
- req_m  in  1  mode: 1 = logic, 0 = arithmetic.
- req_cn  in  1  carry-in, 74181 polarity: 1 = no carry.
- abort  in  1  synchronous abort of an in-flight operation.
- alu_a, alu_b  out  4  current nibble to the ALU.
- alu_s  out  4  function select to the ALU.
- alu_m  out  1  mode to the ALU.
- alu_cn  out  1  carry-in to the ALU.
- alu_f  in  4  ALU result (combinational from alu_* outputs).
- alu_cn4  in  1  ALU carry-out, 74181 polarity: 0 = carry.
- alu_aeqb  in  1  ALU A=B output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_f  out  W  assembled result.
- rsp_cn4  out  1  carry-out of the most significant nibble.
- rsp_aeqb  out  1  AND of alu_aeqb over all nibbles.

## Operation
- States are IDLE, RUN and DONE. A 3-bit nibble index `idx` selects the current nibble.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, register a, b, s, m and cn into operand registers.
  - Clear idx, clear the result register, and set the aeqb accumulator to 1.
  - Move to RUN.
- RUN:
  - alu_a = a_q[4*idx +: 4] and alu_b = b_q[4*idx +: 4]. alu_s and alu_m come from the registers.
  - alu_cn = cn_q when idx = 0, otherwise the carry register (last captured alu_cn4).
  - Each cycle, capture alu_f into f_q[4*idx +: 4] and alu_cn4 into the carry register, and AND alu_aeqb into the accumulator.
  - After capture, idx increments. When idx = NIBBLES-1 is captured, move to DONE.
- DONE:
  - rsp_valid = 1. rsp_f, rsp_cn4 and rsp_aeqb hold stable until rsp_valid & rsp_ready, then move to IDLE.
  - req_ready = 0.
- The carry chain is used unchanged in logic mode (M=1). rsp_cn4 reports whatever the ALU drives.
- In IDLE and DONE, the ALU port drive is alu_a = alu_b = 0, alu_s = 0, alu_m = 1, alu_cn = 1.
- abort is effective in RUN only. The block returns to IDLE at the next edge, does not assert rsp_valid, and discards partial results. abort is ignored in IDLE and DONE.
- Requests presented while req_ready = 0 are not accepted. The requester must hold req_valid and its data.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1.
  - rsp_valid = 0, rsp_f = 0, rsp_cn4 = 1, rsp_aeqb = 0.
  - idx = 0; alu_* outputs take their IDLE values.
- Reset asserted in any state returns the block to IDLE immediately. Any in-flight operation and any pending response is lost.
- Latency: with accept at edge 0, nibble i is captured at edge i+1 and rsp_valid rises at edge NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles with rsp_ready held high. The response handshake edge goes to IDLE, and the next accept happens at the following edge.
- The ALU path is combinational from the alu_* outputs back to alu_f/alu_cn4/alu_aeqb within one cycle.
- rsp_* are registered; no combinational path from req_* to rsp_*.
- The NIBBLES = 1 boundary: RUN lasts one cycle, and alu_cn = cn_q.

## Test plan
Bench uses a behavioural 74181 model on the alu_* ports, with NIBBLES = 4.
- Add, no carry in: M=0, S=1001, Cn=1, A=0x00FF, B=0x0001 -> rsp_f=0x0100, rsp_cn4=1, rsp_valid exactly 4 cycles after accept.
- Carry out: M=0, S=1001, Cn=1, A=0xFFFF, B=0x0001 -> rsp_f=0x0000, rsp_cn4=0.
- Compare: M=0, S=0110, Cn=1, A=B=0x1234 -> rsp_f=0xFFFF, rsp_aeqb=1. Repeat with A=0x1235 -> rsp_aeqb=0.
- Logic XOR: M=1, S=0110, A=0xF0F0, B=0xFF00 -> rsp_f=0x0FF0.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready=0, and a second req_valid is not accepted. Release rsp_ready -> req_ready=1 next cycle, and the second operation completes correctly.
- Abort and reset: assert abort after 2 nibbles -> IDLE next edge, no rsp_valid. Pulse resetb low mid-RUN -> all outputs at reset values. A following add (0x0001 + 0x0000 -> 0x0001) is correct in both cases.
